// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one combinational 4x4 array multiplier between two
// requesters. Round-robin grant in IDLE, registered operands held for SETTLE
// cycles while the array resolves, then the product is captured into a
// valid/ready response register.
// Optional build macro MULT_SELFCHECK_EN adds a sticky chk_err output that
// flags a captured product disagreeing with mul_a*mul_b.
module mult_share_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_p,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_p,
  input  logic       rsp_ready,
`ifdef MULT_SELFCHECK_EN
  output logic       chk_err,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state_q, state_d;
  logic       rr_q, rr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mul_a_q, mul_a_d;
  logic [3:0] mul_b_q, mul_b_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_p_q, rsp_p_d;
  logic       any_req;
  logic       grant;
  logic       xfer;
`ifdef MULT_SELFCHECK_EN
  logic       chk_err_q, chk_err_d;
  logic [7:0] ref_p;
`endif

  // Grant: a lone requester wins outright; on contention rr_q picks the winner.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
    // Ready is masked during reset so nothing appears accepted while held in reset.
    xfer       = (state_q == IDLE) && any_req && !rst;
    req0_ready = xfer && !grant;
    req1_ready = xfer && grant;
  end

`ifdef MULT_SELFCHECK_EN
  // Reference product used only to audit the external array at capture time.
  always_comb begin
    ref_p = {4'b0, mul_a_q} * {4'b0, mul_b_q};
  end
`endif

  // Next-state and datapath updates for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
`ifdef MULT_SELFCHECK_EN
    chk_err_d   = chk_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          mul_a_d  = grant ? req1_a : req0_a;
          mul_b_d  = grant ? req1_b : req0_b;
          rsp_id_d = grant;
          cnt_d    = SETTLE_C;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_p_d     = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef MULT_SELFCHECK_EN
          if (mul_p != ref_p) chk_err_d = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // The requester just served drops to lower priority.
          rr_d        = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= 4'd0;
      mul_a_q     <= 4'd0;
      mul_b_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_p_q     <= 8'd0;
`ifdef MULT_SELFCHECK_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
`ifdef MULT_SELFCHECK_EN
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  // Output mapping.
  always_comb begin
    mul_a     = mul_a_q;
    mul_b     = mul_b_q;
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_p     = rsp_p_q;
    busy      = (state_q != IDLE);
`ifdef MULT_SELFCHECK_EN
    chk_err   = chk_err_q;
`endif
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: three instances (SETTLE = 2, 1, 15) each driving
// a behavioural 4x4 multiplier stub; a round-robin / product / latency model
// lives in the bench.
module tb_mult_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic corrupt = 1'b0;

  logic [2:0]      req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0][3:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic [2:0][7:0] mul_p, rsp_p;
  logic [2:0]      rsp_valid, rsp_id, rsp_ready, busy;
`ifdef MULT_SELFCHECK_EN
  logic [2:0]      chk_err;
`endif

  int total = 0;
  int bad = 0;
  bit rr_m [3];

  always #5 clk = ~clk;

  function automatic int st_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  // Expected product of the multiplier stub (deliberately wrong for 3*3 when corrupt).
  function automatic logic [7:0] model_p(input logic [3:0] a, input logic [3:0] b);
    if (corrupt && a == 4'd3 && b == 4'd3) return 8'h00;
    return {4'b0, a} * {4'b0, b};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign mul_p[g] = model_p(mul_a[g], mul_b[g]);
    mult_share_ctrl #(.SETTLE(st_of(g))) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid[g]), .req0_a(req0_a[g]), .req0_b(req0_b[g]), .req0_ready(req0_ready[g]),
      .req1_valid(req1_valid[g]), .req1_a(req1_a[g]), .req1_b(req1_b[g]), .req1_ready(req1_ready[g]),
      .mul_a(mul_a[g]), .mul_b(mul_b[g]), .mul_p(mul_p[g]),
      .rsp_valid(rsp_valid[g]), .rsp_id(rsp_id[g]), .rsp_p(rsp_p[g]), .rsp_ready(rsp_ready[g]),
`ifdef MULT_SELFCHECK_EN
      .chk_err(chk_err[g]),
`endif
      .busy(busy[g])
    );
  end

  // One full transaction on instance k, checked against the model.
  task automatic run_op(input int k, input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                        input bit v1, input logic [3:0] a1, input logic [3:0] b1, input int bp);
    bit g;
    logic [3:0] ea, eb;
    logic [7:0] ep;
    int lat;
    bit done;
    @(negedge clk);
    req0_valid[k] = v0; req0_a[k] = a0; req0_b[k] = b0;
    req1_valid[k] = v1; req1_a[k] = a1; req1_b[k] = b1;
    rsp_ready[k] = 1'b0;
    #1;
    g  = (v0 && v1) ? rr_m[k] : v1;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    ep = model_p(ea, eb);
    total++;
    if ({req0_ready[k], req1_ready[k]} !== (g ? 2'b01 : 2'b10)) begin
      bad++; $display("FAIL grant inst%0d: got %b want %b", k, {req0_ready[k], req1_ready[k]}, (g ? 2'b01 : 2'b10));
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy[k], req0_ready[k], req1_ready[k]} !== 3'b100) begin
      bad++; $display("FAIL accept_busy inst%0d: got %b want 100", k, {busy[k], req0_ready[k], req1_ready[k]});
    end
    // Granted requester moves on to new operands; they must not leak in.
    if (g) begin req1_a[k] = 4'($urandom); req1_b[k] = 4'($urandom); end
    else   begin req0_a[k] = 4'($urandom); req0_b[k] = 4'($urandom); end
    lat = 0; done = 0;
    while (!done && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) done = 1;
      else begin
        total++;
        if ({busy[k], req0_ready[k], req1_ready[k]} !== 3'b100) begin
          bad++; $display("FAIL wait_busy inst%0d: got %b want 100", k, {busy[k], req0_ready[k], req1_ready[k]});
        end
      end
    end
    total++;
    if (!done || lat != st_of(k)) begin
      bad++; $display("FAIL latency inst%0d: got %0d (seen=%0d) want %0d", k, lat, done, st_of(k));
    end
    total++;
    if ({rsp_id[k], rsp_p[k], mul_a[k], mul_b[k]} !== {g, ep, ea, eb}) begin
      bad++; $display("FAIL response inst%0d: got id=%0d p=%h a=%h b=%h want id=%0d p=%h a=%h b=%h",
                      k, rsp_id[k], rsp_p[k], mul_a[k], mul_b[k], g, ep, ea, eb);
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({rsp_valid[k], rsp_id[k], rsp_p[k], busy[k], req0_ready[k], req1_ready[k]} !== {1'b1, g, ep, 3'b100}) begin
        bad++; $display("FAIL hold inst%0d cyc%0d: got v=%0d id=%0d p=%h busy=%0d rdy=%b want v=1 id=%0d p=%h busy=1 rdy=00",
                        k, i, rsp_valid[k], rsp_id[k], rsp_p[k], busy[k], {req0_ready[k], req1_ready[k]}, g, ep);
      end
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({rsp_valid[k], busy[k], mul_a[k], mul_b[k]} !== {2'b00, ea, eb}) begin
      bad++; $display("FAIL release inst%0d: got v=%0d busy=%0d a=%h b=%h want v=0 busy=0 a=%h b=%h",
                      k, rsp_valid[k], busy[k], mul_a[k], mul_b[k], ea, eb);
    end
    rsp_ready[k] = 1'b0;
    req0_valid[k] = 1'b0; req1_valid[k] = 1'b0;
    rr_m[k] = ~g;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) rr_m[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({mul_a[0], mul_b[0], rsp_valid[0], rsp_id[0], rsp_p[0], req0_ready[0], req1_ready[0], busy[0]} !== 22'd0) begin
      bad++; $display("FAIL reset_vals: got a=%h b=%h v=%0d id=%0d p=%h rdy=%b busy=%0d want all 0",
                      mul_a[0], mul_b[0], rsp_valid[0], rsp_id[0], rsp_p[0], {req0_ready[0], req1_ready[0]}, busy[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    req0_valid[0] = 1'b1; req0_a[0] = 4'hF; req0_b[0] = 4'hF;
    @(posedge clk); @(negedge clk);
    total++;
    if ({busy[0], mul_a[0], mul_b[0]} !== {1'b1, 8'hFF}) begin
      bad++; $display("FAIL reset_pre_busy: got busy=%0d a=%h b=%h want busy=1 a=f b=f", busy[0], mul_a[0], mul_b[0]);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({mul_a[0], mul_b[0], rsp_valid[0], rsp_id[0], rsp_p[0], req0_ready[0], req1_ready[0], busy[0]} !== 22'd0) begin
      bad++; $display("FAIL reset_midwait: got a=%h b=%h v=%0d id=%0d p=%h rdy=%b busy=%0d want all 0",
                      mul_a[0], mul_b[0], rsp_valid[0], rsp_id[0], rsp_p[0], {req0_ready[0], req1_ready[0]}, busy[0]);
    end
    @(negedge clk);
    rst = 1'b0; req0_valid[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid[0], busy[0]} !== 2'b00) begin
        bad++; $display("FAIL reset_no_replay cyc%0d: got v=%0d busy=%0d want 0 0", i, rsp_valid[0], busy[0]);
      end
    end
    for (int i = 0; i < 3; i++) rr_m[i] = 1'b0;
  endtask

  task automatic test_single();
    run_op(0, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 0);
  endtask

  task automatic test_round_robin();
    pulse_reset();
    run_op(0, 1'b1, 4'd5, 4'd3, 1'b1, 4'd2, 4'd3, 0);
    run_op(0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd3, 0);
    run_op(0, 1'b1, 4'd9, 4'd9, 1'b1, 4'd2, 4'd3, 0);
    run_op(0, 1'b1, 4'd9, 4'd9, 1'b1, 4'd4, 4'd4, 0);
  endtask

  task automatic test_backpressure();
    run_op(0, 1'b1, 4'hB, 4'hD, 1'b0, 4'h0, 4'h0, 6);
  endtask

  task automatic test_boundary();
    for (int k = 0; k < 3; k++) begin
      run_op(k, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 0);
      run_op(k, 1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 4'h0, 0);
      run_op(k, 1'b0, 4'h0, 4'h0, 1'b1, 4'h9, 4'h9, 1);
      run_op(k, 1'b1, 4'hD, 4'hB, 1'b1, 4'h7, 4'h2, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int v;
      v = $urandom_range(1, 3);
      run_op(0, v[0], 4'($urandom), 4'($urandom), v[1], 4'($urandom), 4'($urandom), $urandom_range(0, 3));
    end
  endtask

`ifdef MULT_SELFCHECK_EN
  task automatic test_selfcheck();
    pulse_reset();
    corrupt = 1'b1;
    run_op(0, 1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 4'd0, 0);
    total++;
    if (chk_err[0] !== 1'b1) begin bad++; $display("FAIL chk_set: got %0d want 1", chk_err[0]); end
    run_op(0, 1'b1, 4'd2, 4'd5, 1'b0, 4'd0, 4'd0, 0);
    total++;
    if (chk_err[0] !== 1'b1) begin bad++; $display("FAIL chk_sticky: got %0d want 1", chk_err[0]); end
    corrupt = 1'b0;
    pulse_reset();
    total++;
    if (chk_err[0] !== 1'b0) begin bad++; $display("FAIL chk_clear: got %0d want 0", chk_err[0]); end
  endtask
`endif

  initial begin
    req0_valid = '0; req1_valid = '0; rsp_ready = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    for (int i = 0; i < 3; i++) rr_m[i] = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_random();
`ifdef MULT_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
